// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: per-latch control words and the hazard unit's FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_HALTED = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Central pipeline controller: combinational latch-control decode with a RUN/HALTED
// FSM and saturating stall/flush performance counters.
module pipeline_hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             PCSrc_mem,
  input  logic             halt_mem,
  input  logic             dREN_ex,
  input  logic [4:0]       regWSEL_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  output pipe_state_t      fd_state,
  output pipe_state_t      de_state,
  output pipe_state_t      em_state,
  output pipe_state_t      mw_state,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  hazard_state_t r_state;
  hazard_state_t w_next_state;
  logic          w_mem_wait;
  logic          w_load_use;
  logic          w_flush;
  logic          w_stall_inc;

  assign w_mem_wait = (dREN_mem | dWEN_mem) & ~dhit;
  // A $zero destination is never really written, so it cannot create a dependency.
  assign w_load_use = dREN_ex & (regWSEL_ex != 5'd0) &
                      ((regWSEL_ex == rs_id) | (uses_rt_id & (regWSEL_ex == rt_id)));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    fd_state     = PIPE_ENABLE;
    de_state     = PIPE_ENABLE;
    em_state     = PIPE_ENABLE;
    mw_state     = PIPE_ENABLE;
    pc_en        = 1'b1;
    w_flush      = 1'b0;
    w_next_state = r_state;
    if (r_state == HZ_HALTED) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_en    = 1'b0;
    end else if (w_mem_wait) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_en    = 1'b0;
    end else if (halt_mem) begin
      fd_state     = PIPE_NOP;
      de_state     = PIPE_NOP;
      em_state     = PIPE_NOP;
      pc_en        = 1'b0;
      w_next_state = HZ_HALTED;
    end else if (PCSrc_mem) begin
      // PC loads the redirect target even without ihit; the stale fetch is dropped.
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      w_flush  = 1'b1;
    end else if (w_load_use) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else if (!ihit) begin
      fd_state = PIPE_NOP;
      pc_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign halted      = (r_state == HZ_HALTED);
  assign w_stall_inc = (r_state == HZ_RUN) & ~pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_flush),
    .count (flush_cycles)
  );

endmodule
